// File: rtl/dual_grant_scheduler_if.sv
// dual_grant_scheduler_if: request/grant bundle between the request sources,
// the scheduler and the shared grant consumer.
//
// Handshake: a grant pair is transferred on every rising clk edge where
// gnt_valid && gnt_ready. While gnt_valid is high and gnt_ready is low, the
// scheduler holds gnt_first/gnt_second/gnt_second_valid stable. gnt_valid only
// drops after an acceptance or a reset.
interface dual_grant_scheduler_if #(
  parameter int N_REQ = 12,
  parameter int IDW   = 4
);
  logic [N_REQ-1:0] req;
  logic             gnt_ready;
  logic             gnt_valid;
  logic [IDW-1:0]   gnt_first;
  logic [IDW-1:0]   gnt_second;
  logic             gnt_second_valid;
  logic [N_REQ-1:0] pend;
  logic             busy;
  logic [1:0]       dbg_state;

  // Scheduler side
  modport slave (
    input  req, gnt_ready,
    output gnt_valid, gnt_first, gnt_second, gnt_second_valid, pend, busy,
           dbg_state
  );

  // Request source / consumer side
  modport master (
    output req, gnt_ready,
    input  gnt_valid, gnt_first, gnt_second, gnt_second_valid, pend, busy,
           dbg_state
  );
endinterface

// File: rtl/dual_grant_scheduler.sv
// dual_grant_scheduler: latches 12 request lines into a sticky pending
// register and issues a primary/secondary grant pair per transaction.
// Default priority: higher index wins. With DUAL_GRANT_ROUND_ROBIN_EN defined,
// the search starts at a rotating pointer and descends with wrap-around.
// dbg_state exposes the FSM state (0 IDLE, 1 SELECT, 2 GRANT).
module dual_grant_scheduler #(
  parameter int N_REQ = 12,
  parameter int IDW   = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  dual_grant_scheduler_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SELECT = 2'd1,
    GRANT  = 2'd2
  } state_t;

  state_t           state_q;
  logic [N_REQ-1:0] pend_q, pend_d;
  logic [N_REQ-1:0] clr;
  logic             accept;
  logic             gnt_valid_q;
  logic [IDW-1:0]   gnt_first_q, gnt_second_q;
  logic             gnt_second_valid_q;

  logic [IDW-1:0]   search_top;
  logic [IDW-1:0]   sel_first, sel_second;
  logic             sel_found, sel_second_valid;
  logic [IDW-1:0]   scan_idx;
  int               idx;

  assign accept = gnt_valid_q && bus.gnt_ready;

`ifdef DUAL_GRANT_ROUND_ROBIN_EN
  logic [IDW-1:0] ptr_q;
  logic [IDW-1:0] last_idx;

  assign search_top = ptr_q;
  assign last_idx   = gnt_second_valid_q ? gnt_second_q : gnt_first_q;

  // Rotate the search start to just below the last granted index on accept
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q <= IDW'(N_REQ - 1);
    end else if (accept) begin
      ptr_q <= (last_idx == '0) ? IDW'(N_REQ - 1) : last_idx - 1'b1;
    end
  end
`else
  assign search_top = IDW'(N_REQ - 1);
`endif

  // Bits of the accepted pair; zero when no transfer happens this edge
  always_comb begin
    clr = '0;
    for (int i = 0; i < N_REQ; i++) begin
      clr[i] = accept && ((gnt_first_q == IDW'(i)) ||
                          (gnt_second_valid_q && (gnt_second_q == IDW'(i))));
    end
  end

  // Set wins over clear so a request re-arms its own accepted grant
  assign pend_d = (pend_q & ~clr) | bus.req;

  // Descending scan of pend from search_top with wrap; first two hits win
  always_comb begin
    sel_first        = '0;
    sel_second       = '0;
    sel_found        = 1'b0;
    sel_second_valid = 1'b0;
    idx              = 0;
    scan_idx         = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = int'(search_top) - k;
      if (idx < 0) idx = idx + N_REQ;
      scan_idx = IDW'(idx);
      if (pend_q[scan_idx]) begin
        if (!sel_found) begin
          sel_first = scan_idx;
          sel_found = 1'b1;
        end else if (!sel_second_valid) begin
          sel_second       = scan_idx;
          sel_second_valid = 1'b1;
        end
      end
    end
  end

  // Sticky pending register
  always_ff @(posedge clk) begin
    if (reset) pend_q <= '0;
    else       pend_q <= pend_d;
  end

  // Transaction FSM with registered grant outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q            <= IDLE;
      gnt_valid_q        <= 1'b0;
      gnt_first_q        <= '0;
      gnt_second_q       <= '0;
      gnt_second_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pend_q != '0) state_q <= SELECT;
        end
        SELECT: begin
          gnt_first_q        <= sel_first;
          gnt_second_q       <= sel_second;
          gnt_second_valid_q <= sel_second_valid;
          gnt_valid_q        <= 1'b1;
          state_q            <= GRANT;
        end
        GRANT: begin
          if (accept) begin
            gnt_valid_q <= 1'b0;
            state_q     <= (pend_d != '0) ? SELECT : IDLE;
          end
        end
        default: begin
          state_q     <= IDLE;
          gnt_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.gnt_valid        = gnt_valid_q;
  assign bus.gnt_first        = gnt_first_q;
  assign bus.gnt_second       = gnt_second_q;
  assign bus.gnt_second_valid = gnt_second_valid_q;
  assign bus.pend             = pend_q;
  assign bus.busy             = (state_q != IDLE);
  assign bus.dbg_state        = state_q;

endmodule

// File: tb/tb_dual_grant_scheduler.sv
// Bench for dual_grant_scheduler: directed steps from the test plan followed
// by a random phase, all checked against a set-based reference model.
module tb_dual_grant_scheduler;

  localparam int N = 12;

  logic clk;
  logic reset;
  int   vectors;
  int   miscompares;

  dual_grant_scheduler_if #(.N_REQ(N), .IDW(4)) bus ();

  dual_grant_scheduler #(.N_REQ(N), .IDW(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state: pending set, presented pair, "selection due" flag
  logic [N-1:0] m_pend;
  logic         m_valid;
  logic         m_sel_due;
  int           m_first, m_second, m_ptr;
  logic         m_sv;

  // Rank of index i when the search starts at top (0 = searched first)
  function automatic int rank_of(int i, int top);
    return (top - i + N) % N;
  endfunction

  // Choose the two best-ranked pending indices
  task automatic model_pick(input logic [N-1:0] p);
    int top;
    int best, second;
`ifdef DUAL_GRANT_ROUND_ROBIN_EN
    top = m_ptr;
`else
    top = N - 1;
`endif
    best = -1; second = -1;
    for (int r = 0; r < N; r++) begin
      for (int i = 0; i < N; i++) begin
        if (p[i] && rank_of(i, top) == r) begin
          if (best < 0) best = i;
          else if (second < 0) second = i;
        end
      end
    end
    m_first  = (best < 0) ? 0 : best;
    m_sv     = (second >= 0);
    m_second = (second < 0) ? 0 : second;
  endtask

  // Advance the model by one clock edge with the inputs present at that edge
  task automatic model_edge(input logic [N-1:0] r, input logic rdy, input logic rst);
    logic [N-1:0] old_p, clr;
    int last;
    if (rst) begin
      m_pend = '0; m_valid = 0; m_sel_due = 0;
      m_first = 0; m_second = 0; m_sv = 0; m_ptr = N - 1;
      return;
    end
    old_p = m_pend;
    clr = '0;
    if (m_valid && rdy) begin
      clr[m_first] = 1'b1;
      if (m_sv) clr[m_second] = 1'b1;
    end
    m_pend = (old_p & ~clr) | r;
    if (m_valid && rdy) begin
      m_valid = 0;
      last = m_sv ? m_second : m_first;
      m_ptr = (last + N - 1) % N;
      m_sel_due = (m_pend != 0);
    end else if (m_sel_due) begin
      model_pick(old_p);
      m_valid = 1; m_sel_due = 0;
    end else if (!m_valid && old_p != 0) begin
      m_sel_due = 1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: model follows the edge, outputs checked 1ns later
  task automatic tick();
    @(posedge clk);
    model_edge(bus.req, bus.gnt_ready, reset);
    #1;
    chk("gnt_valid", 32'(bus.gnt_valid), 32'(m_valid));
    chk("pend", 32'(bus.pend), 32'(m_pend));
    chk("busy", 32'(bus.busy), 32'(m_valid || m_sel_due));
    if (m_valid) begin
      chk("gnt_first", 32'(bus.gnt_first), 32'(m_first));
      chk("gnt_second", 32'(bus.gnt_second), 32'(m_second));
      chk("gnt_second_valid", 32'(bus.gnt_second_valid), 32'(m_sv));
    end
  endtask

  // Wait (bounded) until a grant pair is presented
  task automatic wait_valid(input string tag);
    int n;
    n = 0;
    while (!bus.gnt_valid && n < 10) begin
      tick();
      n++;
    end
    chk({tag, "_wait_valid"}, 32'(bus.gnt_valid), 32'd1);
  endtask

  int f_first[7];
  int f_second[7];
  int exp_first[7];
  int exp_second[7];
  int got;

  initial begin
    vectors = 0; miscompares = 0;
    reset = 1'b1;
    bus.req = '0; bus.gnt_ready = 1'b0;
    m_pend = '0; m_valid = 0; m_sel_due = 0;
    m_first = 0; m_second = 0; m_sv = 0; m_ptr = N - 1;

    // Reset with all requests asserted
    bus.req = 12'hFFF;
    tick(); tick();
    chk("rst_pend", 32'(bus.pend), 32'h0);
    chk("rst_valid", 32'(bus.gnt_valid), 32'h0);
    chk("rst_first", 32'(bus.gnt_first), 32'h0);
    chk("rst_second", 32'(bus.gnt_second), 32'h0);
    chk("rst_second_valid", 32'(bus.gnt_second_valid), 32'h0);
    chk("rst_busy", 32'(bus.busy), 32'h0);
    reset = 1'b0; bus.req = '0;
    tick(); tick(); tick();
    chk("idle_busy", 32'(bus.busy), 32'h0);

    // Basic pair: valid after the second edge following the request
    bus.gnt_ready = 1'b1;
    bus.req = 12'h810; tick();
    bus.req = '0; tick();
    chk("pair_not_yet", 32'(bus.gnt_valid), 32'h0);
    tick();
    chk("pair_valid", 32'(bus.gnt_valid), 32'h1);
    chk("pair_first", 32'(bus.gnt_first), 32'd11);
    chk("pair_second", 32'(bus.gnt_second), 32'd4);
    chk("pair_sv", 32'(bus.gnt_second_valid), 32'h1);
    tick();
    chk("pair_pend_cleared", 32'(bus.pend), 32'h0);
    chk("pair_idle", 32'(bus.busy), 32'h0);

    // Single request
    bus.req = 12'h001; tick();
    bus.req = '0;
    wait_valid("single");
    chk("single_first", 32'(bus.gnt_first), 32'd0);
    chk("single_second", 32'(bus.gnt_second), 32'd0);
    chk("single_sv", 32'(bus.gnt_second_valid), 32'h0);
    tick();
    chk("single_pend_cleared", 32'(bus.pend), 32'h0);

    // Backpressure with a request arriving during the stall
    bus.gnt_ready = 1'b0;
    bus.req = 12'h00F; tick();
    bus.req = '0;
    wait_valid("bp");
    tick(); tick();
    bus.req = 12'h200; tick();
    bus.req = '0; tick(); tick();
    chk("bp_first", 32'(bus.gnt_first), 32'd3);
    chk("bp_second", 32'(bus.gnt_second), 32'd2);
    chk("bp_pend", 32'(bus.pend), 32'h20F);
    bus.gnt_ready = 1'b1; tick();
    wait_valid("bp_next");
    chk("bp_next_first", 32'(bus.gnt_first), 32'd9);
    chk("bp_next_second", 32'(bus.gnt_second), 32'd1);
    for (int i = 0; i < 6; i++) tick();
    chk("bp_drained", 32'(bus.pend), 32'h0);

    // Re-arm during accept, then reset while a grant is presented
    bus.gnt_ready = 1'b0;
    bus.req = 12'h00F; tick();
    bus.req = '0;
    wait_valid("rearm");
    bus.gnt_ready = 1'b1; bus.req = 12'h008; tick();
    chk("rearm_bit3", 32'(bus.pend[3]), 32'h1);
    bus.gnt_ready = 1'b0; bus.req = '0;
    wait_valid("rearm_next");
    reset = 1'b1; tick();
    chk("midrst_valid", 32'(bus.gnt_valid), 32'h0);
    chk("midrst_pend", 32'(bus.pend), 32'h0);
    reset = 1'b0;

    // Fairness with all requests held and the consumer always ready
`ifdef DUAL_GRANT_ROUND_ROBIN_EN
    exp_first  = '{11, 9, 7, 5, 3, 1, 11};
    exp_second = '{10, 8, 6, 4, 2, 0, 10};
`else
    exp_first  = '{11, 11, 11, 11, 11, 11, 11};
    exp_second = '{10, 10, 10, 10, 10, 10, 10};
`endif
    reset = 1'b1; tick(); reset = 1'b0;
    bus.req = 12'hFFF; bus.gnt_ready = 1'b1;
    got = 0;
    for (int c = 0; c < 40 && got < 7; c++) begin
      tick();
      if (bus.gnt_valid) begin
        f_first[got]  = int'(bus.gnt_first);
        f_second[got] = int'(bus.gnt_second);
        got++;
      end
    end
    chk("fair_count", 32'(got), 32'd7);
    for (int i = 0; i < got; i++) begin
      chk($sformatf("fair_first_%0d", i), 32'(f_first[i]), 32'(exp_first[i]));
      chk($sformatf("fair_second_%0d", i), 32'(f_second[i]), 32'(exp_second[i]));
    end

    // Random traffic, occasional reset
    bus.req = '0;
    for (int c = 0; c < 400; c++) begin
      bus.req       = ($urandom_range(0, 3) == 0) ? 12'($urandom_range(0, 4095)) : 12'h0;
      bus.gnt_ready = ($urandom_range(0, 2) != 0);
      reset         = ($urandom_range(0, 99) == 0);
      tick();
    end
    reset = 1'b0; bus.req = '0; bus.gnt_ready = 1'b1;
    for (int c = 0; c < 30; c++) tick();
    chk("final_idle", 32'(bus.busy), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
